// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: owns the EX/MEM and MEM/WB control registers (op, rd, writes-rd)
// consumed by the EX forwarding muxes. Also derives the F/D stall, D flush and E bubble
// controls from load-use and taken branch/jump conditions. Every stage holds while
// instruction or data memory is busy.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the lu_cnt / flush_cnt event counters.
module hazard_pipe_tracker #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_op,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic             is_D_use_rs1,
    input  logic             is_D_use_rs2,
    input  logic [4:0]       E_op,
    input  logic [4:0]       E_rd,
    input  logic             jb_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic [4:0]       M_op,
    output logic [4:0]       M_rd,
    output logic [4:0]       W_op,
    output logic [4:0]       W_rd,
    output logic             is_M_use_rd,
    output logic             is_W_use_rd,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             bubble_E,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             stall_all
);

    // Opcode encodings, inst[6:2]
    localparam logic [4:0] OP_R   = 5'b01100;
    localparam logic [4:0] OP_I1  = 5'b00000; // load
    localparam logic [4:0] OP_I2  = 5'b00100; // ALU immediate, also the NOP op
    localparam logic [4:0] OP_I3  = 5'b11001; // jalr
    localparam logic [4:0] OP_U1  = 5'b01101; // lui
    localparam logic [4:0] OP_U2  = 5'b00101; // auipc
    localparam logic [4:0] OP_J   = 5'b11011; // jal
    localparam logic [4:0] OP_CSR = 5'b11100;

    function automatic logic f_writes_rd(input logic [4:0] op);
        logic wr;
        case (op)
            OP_R, OP_I1, OP_I2, OP_I3, OP_U1, OP_U2, OP_J, OP_CSR: wr = 1'b1;
            default:                                              wr = 1'b0;
        endcase
        return wr;
    endfunction

    logic       w_stall_all;
    logic       w_load_use;
    logic [4:0] r_M_op, r_M_rd, r_W_op, r_W_rd;
    logic       r_M_use_rd, r_W_use_rd;

    // D_op is part of the ID interface but no hazard rule depends on it
    logic w_unused;
    assign w_unused = ^{D_op, (CNT_W != 32'd0)};

    // Memory busy freezes the whole pipe; load-use compares ID sources against EX load rd
    always_comb begin
        w_stall_all = imem_stall | dmem_stall;
        w_load_use  = (E_op == OP_I1) && (E_rd != 5'd0) &&
                      ((is_D_use_rs1 && (D_rs1 == E_rd)) || (is_D_use_rs2 && (D_rs2 == E_rd)));
    end

    // Hazard controls: memory stall > taken branch/jump > load-use > none
    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        flush_D  = 1'b0;
        bubble_E = 1'b0;
        if (w_stall_all) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
        end else if (jb_taken) begin
            flush_D  = 1'b1;
            bubble_E = 1'b1;
        end else if (w_load_use) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            bubble_E = 1'b1;
        end
    end

    // EX/MEM and MEM/WB control registers; reset loads NOP, memory stall holds both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_M_op     <= OP_I2;
            r_M_rd     <= 5'd0;
            r_M_use_rd <= 1'b0;
            r_W_op     <= OP_I2;
            r_W_rd     <= 5'd0;
            r_W_use_rd <= 1'b0;
        end else if (!w_stall_all) begin
            r_M_op     <= E_op;
            r_M_rd     <= E_rd;
            r_M_use_rd <= f_writes_rd(E_op);
            r_W_op     <= r_M_op;
            r_W_rd     <= r_M_rd;
            r_W_use_rd <= r_M_use_rd;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_lu_cnt, r_flush_cnt;

    // Event counters advance only on cycles the pipe actually moves; wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lu_cnt    <= '0;
            r_flush_cnt <= '0;
        end else if (!w_stall_all) begin
            if (jb_taken) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (w_load_use) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
        end
    end

    assign lu_cnt    = r_lu_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

    assign M_op        = r_M_op;
    assign M_rd        = r_M_rd;
    assign W_op        = r_W_op;
    assign W_rd        = r_W_rd;
    assign is_M_use_rd = r_M_use_rd;
    assign is_W_use_rd = r_W_use_rd;
    assign stall_all   = w_stall_all;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Bench for hazard_pipe_tracker: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a queue-based model of the two control stages.
module tb_hazard_pipe_tracker;

    localparam int unsigned CNT_W = 32;

    localparam logic [4:0] T_R   = 5'b01100;
    localparam logic [4:0] T_I1  = 5'b00000;
    localparam logic [4:0] T_I2  = 5'b00100;
    localparam logic [4:0] T_I3  = 5'b11001;
    localparam logic [4:0] T_S   = 5'b01000;
    localparam logic [4:0] T_B   = 5'b11000;
    localparam logic [4:0] T_U1  = 5'b01101;
    localparam logic [4:0] T_U2  = 5'b00101;
    localparam logic [4:0] T_J   = 5'b11011;
    localparam logic [4:0] T_CSR = 5'b11100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] D_op, D_rs1, D_rs2, E_op, E_rd;
    logic       is_D_use_rs1, is_D_use_rs2, jb_taken, imem_stall, dmem_stall;
    logic [4:0] M_op, M_rd, W_op, W_rd;
    logic       is_M_use_rd, is_W_use_rd, stall_F, stall_D, flush_D, bubble_E, stall_all;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt, flush_cnt;
`endif

    hazard_pipe_tracker #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .D_op         (D_op),
        .D_rs1        (D_rs1),
        .D_rs2        (D_rs2),
        .is_D_use_rs1 (is_D_use_rs1),
        .is_D_use_rs2 (is_D_use_rs2),
        .E_op         (E_op),
        .E_rd         (E_rd),
        .jb_taken     (jb_taken),
        .imem_stall   (imem_stall),
        .dmem_stall   (dmem_stall),
        .M_op         (M_op),
        .M_rd         (M_rd),
        .W_op         (W_op),
        .W_rd         (W_rd),
        .is_M_use_rd  (is_M_use_rd),
        .is_W_use_rd  (is_W_use_rd),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .flush_D      (flush_D),
        .bubble_E     (bubble_E),
`ifdef HAZARD_PERF_CNT_EN
        .lu_cnt       (lu_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .stall_all    (stall_all)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0] op;
        logic [4:0] rd;
        logic       wr;
    } stage_t;

    // pipe[0] is the MEM-stage instruction, pipe[1] the WB-stage instruction
    stage_t      pipe[2];
    logic [31:0] m_lu, m_flush;

    function automatic logic m_writes(input logic [4:0] op);
        logic [4:0] wr_ops[8];
        wr_ops = '{T_R, T_I1, T_I2, T_I3, T_U1, T_U2, T_J, T_CSR};
        foreach (wr_ops[i]) if (wr_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_load_use();
        if (E_op != T_I1 || E_rd == 5'd0) return 1'b0;
        return (is_D_use_rs1 && D_rs1 == E_rd) || (is_D_use_rs2 && D_rs2 == E_rd);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] = '{op: T_I2, rd: 5'd0, wr: 1'b0};
            pipe[1] = '{op: T_I2, rd: 5'd0, wr: 1'b0};
            m_lu    = 0;
            m_flush = 0;
        end else if (!(imem_stall || dmem_stall)) begin
            if (jb_taken) m_flush = m_flush + 1;
            else if (m_load_use()) m_lu = m_lu + 1;
            pipe[1] = pipe[0];
            pipe[0] = '{op: E_op, rd: E_rd, wr: m_writes(E_op)};
        end
    end

    // Compare every cycle on the falling edge, away from the register update
    always @(negedge clk) begin
        logic mstall, exp_sf, exp_fl, exp_bb;
        mstall = imem_stall || dmem_stall;
        exp_sf = mstall || (!jb_taken && m_load_use());
        exp_fl = !mstall && jb_taken;
        exp_bb = !mstall && (jb_taken || m_load_use());
        chk("M_op", M_op, pipe[0].op);
        chk("M_rd", M_rd, pipe[0].rd);
        chk("is_M_use_rd", is_M_use_rd, pipe[0].wr);
        chk("W_op", W_op, pipe[1].op);
        chk("W_rd", W_rd, pipe[1].rd);
        chk("is_W_use_rd", is_W_use_rd, pipe[1].wr);
        chk("stall_all", stall_all, mstall);
        chk("stall_F", stall_F, exp_sf);
        chk("stall_D", stall_D, exp_sf);
        chk("flush_D", flush_D, exp_fl);
        chk("bubble_E", bubble_E, exp_bb);
`ifdef HAZARD_PERF_CNT_EN
        chk("lu_cnt", lu_cnt, m_lu);
        chk("flush_cnt", flush_cnt, m_flush);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic [4:0] op, input logic [4:0] rd);
        E_op = op;
        E_rd = rd;
    endtask

    function automatic logic [4:0] pick_op();
        logic [4:0] ops[10];
        ops = '{T_R, T_I1, T_I2, T_I3, T_S, T_B, T_U1, T_U2, T_J, T_CSR};
        if ($urandom_range(0, 4) == 0) return 5'($urandom);
        return ops[$urandom_range(0, 9)];
    endfunction

    initial begin
        logic [31:0] fc0;
        rst = 1'b1;
        D_op = T_R; D_rs1 = 0; D_rs2 = 0; is_D_use_rs1 = 0; is_D_use_rs2 = 0;
        E_op = T_I2; E_rd = 0; jb_taken = 0; imem_stall = 0; dmem_stall = 0;
        #12;
        rst = 1'b0;
        #1;
        // 1: reset state visible before the first edge
        chk("rst M_op", M_op, 5'b00100);
        chk("rst W_op", W_op, 5'b00100);
        chk("rst M_rd", M_rd, 0);
        chk("rst W_rd", W_rd, 0);
        chk("rst use_rd", {is_M_use_rd, is_W_use_rd}, 0);

        // 2: load-use
        step();
        set_e(T_I1, 5'd5); D_rs1 = 5; is_D_use_rs1 = 1;
        #1;
        chk("lu stall", {stall_F, stall_D, bubble_E, flush_D}, 4'b1110);
        step();
        set_e(T_I2, 5'd0);
        #1;
        chk("lu M_rd", M_rd, 5);
        chk("lu M_use", is_M_use_rd, 1);
        chk("lu clear", {stall_F, stall_D, bubble_E, flush_D}, 4'b0000);

        // 3: taken branch wins over load-use
        set_e(T_I1, 5'd5); jb_taken = 1;
        #1;
        chk("jb prio", {stall_F, stall_D, bubble_E, flush_D}, 4'b0011);
        step();
        jb_taken = 0; is_D_use_rs1 = 0;

        // 4: store does not write rd
        set_e(T_S, 5'd7);
        step();
        chk("sw M_rd", M_rd, 7);
        chk("sw M_use", is_M_use_rd, 0);
        set_e(T_I2, 5'd0);
        step();
        chk("sw W_rd", W_rd, 7);
        chk("sw W_use", is_W_use_rd, 0);

        // 5: dmem stall freezes M and W
        set_e(T_R, 5'd9);
        step();
        dmem_stall = 1; jb_taken = 1;
        for (int i = 0; i < 3; i++) begin
            set_e(T_U1, 5'(10 + i));
            #1;
            chk("stl M_rd", M_rd, 9);
            chk("stl W_rd", W_rd, 0);
            chk("stl ctl", {stall_all, stall_F, stall_D, flush_D, bubble_E}, 5'b11100);
            step();
        end
        dmem_stall = 0; jb_taken = 0;
        set_e(T_U1, 5'd12);
        step();
        chk("rel M_rd", M_rd, 12);
        chk("rel W_rd", W_rd, 9);

        // 6: load to x0 never stalls
        set_e(T_I1, 5'd0); D_rs1 = 0; is_D_use_rs1 = 1;
        #1;
        chk("x0 nostall", {stall_F, bubble_E}, 2'b00);
        is_D_use_rs1 = 0;

        // Four taken branches
        fc0 = m_flush;
        step();
        jb_taken = 1;
        for (int i = 0; i < 4; i++) step();
        jb_taken = 0;
        chk("model flush +4", m_flush - fc0, 4);
`ifdef HAZARD_PERF_CNT_EN
        chk("flush_cnt +4", flush_cnt - fc0, 4);
`endif

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            step();
            if (rst) rst = 1'b0;
            set_e(pick_op(), 5'($urandom));
            if ($urandom_range(0, 2) == 0) E_op = T_I1;
            D_op         = pick_op();
            D_rs1        = ($urandom_range(0, 2) == 0) ? E_rd : 5'($urandom);
            D_rs2        = ($urandom_range(0, 2) == 0) ? E_rd : 5'($urandom);
            is_D_use_rs1 = 1'($urandom);
            is_D_use_rs2 = 1'($urandom);
            jb_taken     = ($urandom_range(0, 5) == 0);
            imem_stall   = ($urandom_range(0, 7) == 0);
            dmem_stall   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
            end
        end
        step();
        rst = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
